// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encodings and
// overflow-policy selectors.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNTING = 2'b01,
        ST_FROZEN   = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with a sticky overflow flag; wraps or saturates at
// all-ones depending on SAT_MODE.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == '1) begin
                ovf <= 1'b1;
                if (SAT_MODE != SAT_SAT) begin
                    count <= '0;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters gated by an IDLE/COUNTING/FROZEN FSM, with a
// one-cycle-latency registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int   NUM_CH   = 4,
    parameter int   CNT_W    = 32,
    parameter int   SAT_MODE = SAT_WRAP,
    localparam int  SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              clear,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic [1:0]        state_out,
    output logic              ovf_any
);

    state_t            state;
    state_t            state_nxt;
    logic              count_en;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] ovf_vec;
    logic [CNT_W-1:0]  counts [NUM_CH];
    logic              sel_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear overrides every other transition, including recovery from 2'b11
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_COUNTING;
            ST_COUNTING: if (halt)  state_nxt = ST_FROZEN;
            ST_FROZEN:   state_nxt = ST_FROZEN;
            default:     state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    assign count_en  = (state == ST_COUNTING) && !clear;
    assign inc       = event_in & {NUM_CH{count_en}};
    assign state_out = state;
    assign ovf_any   = |ovf_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[i]),
            .clr   (clear),
            .count (counts[i]),
            .ovf   (ovf_vec[i])
        );
    end

    assign sel_ok = int'({1'b0, rd_sel}) < NUM_CH;

    // Response samples pre-edge counter state, so it reflects the request cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (sel_ok) begin
                    rd_data <= counts[rd_sel];
                    rd_ovf  <= ovf_vec[rd_sel];
                end else begin
                    rd_data <= '0;
                    rd_ovf  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench: a default bank plus two 3-channel 8-bit banks
// (wrap and saturate) driven with identical stimulus.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, start_a = 1'b0, halt_a = 1'b0, clear_a = 1'b0;
    logic [3:0]  ev_a = '0;
    logic        rd_req_a = 1'b0;
    logic [1:0]  rd_sel_a = '0;
    logic        rd_valid_a, rd_ovf_a, ovf_any_a;
    logic [31:0] rd_data_a;
    logic [1:0]  state_a;

    logic        rst_b = 1'b0, start_b = 1'b0, halt_b = 1'b0, clear_b = 1'b0;
    logic [2:0]  ev_b = '0;
    logic        rd_req_b = 1'b0;
    logic [1:0]  rd_sel_b = '0;
    logic        rd_valid_w, rd_ovf_w, ovf_any_w, rd_valid_s, rd_ovf_s, ovf_any_s;
    logic [7:0]  rd_data_w, rd_data_s;
    logic [1:0]  state_w, state_s;

    int unsigned checks = 0;
    int unsigned errors = 0;

    perf_counter_bank dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .halt(halt_a), .clear(clear_a),
        .event_in(ev_a), .rd_req(rd_req_a), .rd_sel(rd_sel_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_ovf(rd_ovf_a),
        .state_out(state_a), .ovf_any(ovf_any_a)
    );

    perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SAT_MODE(0)) dut_w (
        .clk(clk), .rst(rst_b), .start(start_b), .halt(halt_b), .clear(clear_b),
        .event_in(ev_b), .rd_req(rd_req_b), .rd_sel(rd_sel_b),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w),
        .state_out(state_w), .ovf_any(ovf_any_w)
    );

    perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SAT_MODE(1)) dut_s (
        .clk(clk), .rst(rst_b), .start(start_b), .halt(halt_b), .clear(clear_b),
        .event_in(ev_b), .rd_req(rd_req_b), .rd_sel(rd_sel_b),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s),
        .state_out(state_s), .ovf_any(ovf_any_s)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input logic [1:0] sel, input logic [31:0] exp_data, input string tag);
        rd_req_a = 1'b1;
        rd_sel_a = sel;
        tick();
        rd_req_a = 1'b0;
        check_eq({tag, "_valid"}, 64'(rd_valid_a), 64'd1);
        check_eq({tag, "_data"}, 64'(rd_data_a), 64'(exp_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2;
        check_eq("rst_valid", 64'(rd_valid_a), 64'd0);
        check_eq("rst_data", 64'(rd_data_a), 64'd0);
        check_eq("rst_state", 64'(state_a), 64'd0);
        check_eq("rst_ovf_any", 64'(ovf_any_a), 64'd0);
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;

        // halt in IDLE ignored
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        check_eq("idle_halt_state", 64'(state_a), 64'd0);

        // start cycle: event not counted
        start_a = 1'b1;
        ev_a = 4'b0101;
        tick();
        start_a = 1'b0;
        check_eq("start_state", 64'(state_a), 64'd1);
        repeat (10) tick();
        ev_a = 4'b0000;
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        check_eq("halt_state", 64'(state_a), 64'd2);
        read_a(2'd0, 32'd10, "b_ch0");
        read_a(2'd1, 32'd0, "b_ch1");
        read_a(2'd3, 32'd0, "b_ch3");
        read_a(2'd2, 32'd10, "b_ch2");
        tick();
        check_eq("idle_valid", 64'(rd_valid_a), 64'd0);
        check_eq("hold_data", 64'(rd_data_a), 64'd10);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("frozen_start_state", 64'(state_a), 64'd2);

        // halt cycle event is counted
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check_eq("clear_state", 64'(state_a), 64'd0);
        read_a(2'd0, 32'd0, "clr_ch0");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ev_a = 4'b0001;
        repeat (5) tick();
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        repeat (3) tick();
        ev_a = 4'b0000;
        read_a(2'd0, 32'd6, "halt_ev_ch0");

        // read coincident with clear returns pre-clear value
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ev_a = 4'b0100;
        repeat (7) tick();
        clear_a = 1'b1;
        rd_req_a = 1'b1;
        rd_sel_a = 2'd2;
        tick();
        clear_a = 1'b0;
        rd_req_a = 1'b0;
        check_eq("clr_rd_data", 64'(rd_data_a), 64'd7);
        check_eq("clr_rd_state", 64'(state_a), 64'd0);
        read_a(2'd2, 32'd0, "after_clr_ch2");
        ev_a = 4'b0000;

        // read samples pre-increment value; then async reset mid-read
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ev_a = 4'b0001;
        repeat (3) tick();
        read_a(2'd0, 32'd3, "pre_inc_ch0");
        rd_req_a = 1'b1;
        #2;
        rst_a = 1'b0;
        #1;
        check_eq("arst_valid", 64'(rd_valid_a), 64'd0);
        check_eq("arst_data", 64'(rd_data_a), 64'd0);
        check_eq("arst_ovf", 64'(rd_ovf_a), 64'd0);
        check_eq("arst_state", 64'(state_a), 64'd0);
        tick();
        rd_req_a = 1'b0;
        rst_a = 1'b1;
        tick();
        check_eq("post_rst_valid", 64'(rd_valid_a), 64'd0);
        check_eq("post_rst_state", 64'(state_a), 64'd0);
        ev_a = 4'b0000;
        read_a(2'd0, 32'd0, "post_rst_ch0");

        // 8-bit wrap / saturate banks: 257 events on channel 1
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ev_b = 3'b010;
        repeat (257) tick();
        ev_b = 3'b000;
        check_eq("w_ovf_any", 64'(ovf_any_w), 64'd1);
        check_eq("s_ovf_any", 64'(ovf_any_s), 64'd1);
        rd_req_b = 1'b1;
        rd_sel_b = 2'd0;
        tick();
        check_eq("w_r0_valid", 64'(rd_valid_w), 64'd1);
        check_eq("w_r0_data", 64'(rd_data_w), 64'd0);
        check_eq("w_r0_ovf", 64'(rd_ovf_w), 64'd0);
        rd_sel_b = 2'd1;
        tick();
        check_eq("w_r1_valid", 64'(rd_valid_w), 64'd1);
        check_eq("w_r1_data", 64'(rd_data_w), 64'h01);
        check_eq("w_r1_ovf", 64'(rd_ovf_w), 64'd1);
        check_eq("s_r1_data", 64'(rd_data_s), 64'hFF);
        check_eq("s_r1_ovf", 64'(rd_ovf_s), 64'd1);
        rd_sel_b = 2'd3;
        tick();
        rd_req_b = 1'b0;
        check_eq("w_oob_valid", 64'(rd_valid_w), 64'd1);
        check_eq("w_oob_data", 64'(rd_data_w), 64'd0);
        check_eq("w_oob_ovf", 64'(rd_ovf_w), 64'd0);
        check_eq("s_oob_ovf", 64'(rd_ovf_s), 64'd0);
        tick();
        check_eq("w_idle_valid", 64'(rd_valid_w), 64'd0);
        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;
        check_eq("w_clr_ovf_any", 64'(ovf_any_w), 64'd0);
        check_eq("s_clr_state", 64'(state_s), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
